// File: rtl/axis_window_crop.sv
// Crops an AXI4-Stream frame to a window and forwards inside pixels with regenerated SOF/EOL, 1-cycle latency; tready = ~m_tvalid | m_tready.
// Define AXIS_WINDOW_CROP_DBG_EN to add the frame/line debug counters.
module axis_window_crop #(
    parameter int C_PIXEL_WIDTH = 8,
    parameter int C_WBITS       = 12,
    parameter int C_HBITS       = 12
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [C_WBITS-1:0]       left,
    input  logic [C_WBITS-1:0]       width,
    input  logic [C_HBITS-1:0]       top,
    input  logic [C_HBITS-1:0]       height,
    input  logic                     s_axis_tvalid,
    input  logic [C_PIXEL_WIDTH-1:0] s_axis_tdata,
    input  logic                     s_axis_tuser,
    input  logic                     s_axis_tlast,
    output logic                     s_axis_tready,
    output logic                     m_axis_tvalid,
    output logic [C_PIXEL_WIDTH-1:0] m_axis_tdata,
    output logic                     m_axis_tuser,
    output logic                     m_axis_tlast,
    input  logic                     m_axis_tready
`ifdef AXIS_WINDOW_CROP_DBG_EN
    ,
    output logic [15:0]              dbg_frame_cnt,
    output logic [C_HBITS-1:0]       dbg_line_cnt
`endif
);

    localparam logic [C_WBITS-1:0] C_COL_ONE = {{(C_WBITS-1){1'b0}}, 1'b1};
    localparam logic [C_HBITS-1:0] C_ROW_ONE = {{(C_HBITS-1){1'b0}}, 1'b1};
    localparam logic [C_WBITS:0]   C_COLX_ONE = {{C_WBITS{1'b0}}, 1'b1};

    logic [C_WBITS-1:0] r_col, r_left, r_width;
    logic [C_HBITS-1:0] r_row, r_top, r_height;
    logic               r_in_frame;
    logic               r_sof_pending;

    logic               w_xfer, w_sof, w_active, w_emit, w_olast, w_sof_pend;
    logic [C_WBITS-1:0] w_col, w_l, w_w, w_col_inc;
    logic [C_HBITS-1:0] w_row, w_t, w_h, w_row_inc;
    logic [C_WBITS:0]   w_col_x, w_l_end;
    logic [C_HBITS:0]   w_row_x, w_t_end;
    logic               w_in_col, w_in_row;

    assign s_axis_tready = ~m_axis_tvalid | m_axis_tready;
    assign w_xfer        = s_axis_tvalid & s_axis_tready;
    assign w_sof         = s_axis_tuser;

    // A tuser beat uses the freshly presented window and sits at (0,0).
    assign w_l      = w_sof ? left   : r_left;
    assign w_w      = w_sof ? width  : r_width;
    assign w_t      = w_sof ? top    : r_top;
    assign w_h      = w_sof ? height : r_height;
    assign w_col    = w_sof ? '0 : r_col;
    assign w_row    = w_sof ? '0 : r_row;
    assign w_active = w_sof | r_in_frame;

    // One extra bit on the window end keeps left+width from wrapping.
    assign w_col_x  = {1'b0, w_col};
    assign w_row_x  = {1'b0, w_row};
    assign w_l_end  = {1'b0, w_l} + {1'b0, w_w};
    assign w_t_end  = {1'b0, w_t} + {1'b0, w_h};
    assign w_in_col = (w_col >= w_l) && (w_col_x < w_l_end);
    assign w_in_row = (w_row >= w_t) && (w_row_x < w_t_end);

    assign w_emit     = w_xfer & w_active & w_in_col & w_in_row;
    assign w_olast    = ((w_col_x + C_COLX_ONE) == w_l_end) | s_axis_tlast;
    assign w_sof_pend = w_sof | r_sof_pending;

    assign w_col_inc = (&w_col) ? w_col : w_col + C_COL_ONE;
    assign w_row_inc = (&w_row) ? w_row : w_row + C_ROW_ONE;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_col         <= '0;
            r_row         <= '0;
            r_left        <= '0;
            r_width       <= '0;
            r_top         <= '0;
            r_height      <= '0;
            r_in_frame    <= 1'b0;
            r_sof_pending <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else begin
            if (w_xfer) begin
                if (w_sof) begin
                    r_left     <= left;
                    r_width    <= width;
                    r_top      <= top;
                    r_height   <= height;
                    r_in_frame <= 1'b1;
                end
                if (s_axis_tlast) begin
                    r_col <= '0;
                    r_row <= w_row_inc;
                end else begin
                    r_col <= w_col_inc;
                    r_row <= w_row;
                end
                r_sof_pending <= w_sof_pend & ~w_emit;
            end
            if (s_axis_tready) begin
                m_axis_tvalid <= w_emit;
                if (w_emit) begin
                    m_axis_tdata <= s_axis_tdata;
                    m_axis_tuser <= w_sof_pend;
                    m_axis_tlast <= w_olast;
                end
            end
        end
    end

`ifdef AXIS_WINDOW_CROP_DBG_EN
    logic w_emit_last;
    assign w_emit_last = w_emit & w_olast;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            dbg_frame_cnt <= '0;
            dbg_line_cnt  <= '0;
        end else if (w_xfer && w_sof) begin
            dbg_frame_cnt <= dbg_frame_cnt + 16'd1;
            dbg_line_cnt  <= w_emit_last ? C_ROW_ONE : '0;
        end else if (w_emit_last) begin
            dbg_line_cnt  <= dbg_line_cnt + C_ROW_ONE;
        end
    end
`endif

endmodule

// File: tb/tb_axis_window_crop.sv
// Bench for axis_window_crop: directed frames plus randomized frames checked against a pixel-list model.
module tb_axis_window_crop;

    typedef struct packed {
        logic [7:0] d;
        logic       u;
        logic       l;
    } beat_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic [11:0] left, width, top, height;
    logic        s_axis_tvalid;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tuser, s_axis_tlast;
    logic        s_axis_tready;
    logic        m_axis_tvalid;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tuser, m_axis_tlast;
    logic        m_axis_tready;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    rdy_mode = 0;
    int    gaps = 0;
    beat_t exp_q[$];
    logic [7:0] pix [0:1023];

    always #5 clk = ~clk;

    axis_window_crop #(.C_PIXEL_WIDTH(8), .C_WBITS(12), .C_HBITS(12)) dut (
        .clk(clk), .resetn(resetn),
        .left(left), .width(width), .top(top), .height(height),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata),
        .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata),
        .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
        .m_axis_tready(m_axis_tready)
    );

    // Downstream ready pattern: 0 = always, 1 = toggle, else random.
    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = ~m_axis_tready;
                default: m_axis_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Output monitor: hold-while-stalled check and scoreboard compare.
    bit    have_prev = 0;
    beat_t prev_beat;
    beat_t got;
    beat_t e;
    always @(negedge clk) begin
        if (resetn !== 1'b1) begin
            have_prev = 0;
        end else begin
            got = {m_axis_tdata, m_axis_tuser, m_axis_tlast};
            if (have_prev) begin
                n_tests++;
                assert (m_axis_tvalid === 1'b1 && got === prev_beat) else begin
                    n_fail++;
                    $error("FAIL stall_hold: got vld=%b beat=%h, exp vld=1 beat=%h", m_axis_tvalid, got, prev_beat);
                end
            end
            have_prev = (m_axis_tvalid === 1'b1) && (m_axis_tready === 1'b0);
            prev_beat = got;
            if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $error("FAIL extra_beat: got beat=%h, exp no output", got);
                end else begin
                    e = exp_q.pop_front();
                    assert (got === e) else begin
                        n_fail++;
                        $error("FAIL beat: got d=%h u=%b l=%b, exp d=%h u=%b l=%b", got.d, got.u, got.l, e.d, e.u, e.l);
                    end
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic u, input logic l);
        bit ok;
        int guard;
        while (gaps != 0 && $urandom_range(0, 2) == 0) begin
            s_axis_tvalid = 1'b0;
            @(posedge clk);
            #1;
        end
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        guard = 0;
        ok    = 0;
        while (!ok) begin
            @(negedge clk);
            ok = s_axis_tready;
            @(posedge clk);
            #1;
            guard++;
            if (!ok && guard > 500) begin
                n_tests++;
                n_fail++;
                $error("FAIL send_timeout: got no tready in %0d cycles, exp tready", guard);
                ok = 1;
            end
        end
    endtask

    // Model: every pixel of the raster inside the window, in raster order,
    // first one flagged SOF, last column of the window or frame flagged EOL.
    task automatic run_frame(input int fw, input int l, input int w, input int t, input int h,
                             input int first, input int last_excl,
                             input int chg_idx, input int chg_left, input bit exp_en);
        bit    sof;
        beat_t b;
        left   = 12'(l);
        width  = 12'(w);
        top    = 12'(t);
        height = 12'(h);
        sof    = 1;
        for (int idx = first; idx < last_excl; idx++) begin
            int r;
            int c;
            r = idx / fw;
            c = idx % fw;
            pix[idx] = 8'($urandom);
            if (exp_en && c >= l && c < l + w && r >= t && r < t + h) begin
                b.d = pix[idx];
                b.u = sof;
                b.l = (c == l + w - 1) || (c == fw - 1);
                exp_q.push_back(b);
                sof = 0;
            end
        end
        for (int idx = first; idx < last_excl; idx++) begin
            if (idx == chg_idx) left = 12'(chg_left);
            send(pix[idx], idx == 0, (idx % fw) == fw - 1);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tuser  = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic drain(input string tag);
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 400) begin
            @(posedge clk);
            g++;
        end
        repeat (4) @(posedge clk);
        #1;
        n_tests++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL %s_missing: got %0d beats still pending, exp 0", tag, exp_q.size());
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish, exp finish");
        $fatal(1, "timeout");
    end

    initial begin
        resetn        = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 8'h00;
        s_axis_tuser  = 1'b0;
        s_axis_tlast  = 1'b0;
        left = 12'd0; width = 12'd0; top = 12'd0; height = 12'd0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        n_tests++;
        assert ({m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast, s_axis_tready} === {1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) else begin
            n_fail++;
            $error("FAIL reset_state: got %b, exp %b", {m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast, s_axis_tready}, 12'b0_00000000_001);
        end
        @(posedge clk);
        #1;

        // Basic 8x4 crop, full-rate then with toggling ready.
        rdy_mode = 0;
        run_frame(8, 2, 3, 1, 2, 0, 32, -1, 0, 1);
        drain("basic");
        rdy_mode = 1;
        run_frame(8, 2, 3, 1, 2, 0, 32, -1, 0, 1);
        drain("toggle");

        // Right-edge clip.
        rdy_mode = 0;
        run_frame(8, 6, 5, 0, 4, 0, 32, -1, 0, 1);
        drain("clip");

        // Empty window, then a 2-pixel window.
        run_frame(8, 0, 0, 0, 4, 0, 32, -1, 0, 1);
        drain("w0");
        run_frame(8, 0, 2, 0, 1, 0, 32, -1, 0, 1);
        drain("w2");

        // Left changes mid-frame; only the next frame sees it.
        run_frame(8, 1, 3, 0, 4, 0, 32, 10, 3, 1);
        drain("latch_old");
        run_frame(8, 3, 3, 0, 4, 0, 32, -1, 0, 1);
        drain("latch_new");

        // Window far right of the frame: sum must not wrap into range.
        run_frame(8, 4095, 2, 0, 2, 0, 16, -1, 0, 1);
        drain("far_right");

        // Reset mid-frame: tail of the frame is dropped, next frame is clean.
        run_frame(8, 0, 8, 0, 4, 0, 13, -1, 0, 1);
        drain("pre_reset");
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        n_tests++;
        assert (m_axis_tvalid === 1'b0) else begin
            n_fail++;
            $error("FAIL post_reset_vld: got %b, exp 0", m_axis_tvalid);
        end
        @(posedge clk);
        #1;
        run_frame(8, 0, 8, 0, 4, 13, 32, -1, 0, 0);
        drain("post_reset_drop");
        run_frame(8, 2, 3, 1, 2, 0, 32, -1, 0, 1);
        drain("post_reset_frame");

        // Randomized frames, windows, gaps and backpressure.
        for (int k = 0; k < 14; k++) begin
            int fw;
            int fh;
            fw       = $urandom_range(1, 12);
            fh       = $urandom_range(1, 6);
            rdy_mode = $urandom_range(0, 2);
            gaps     = $urandom_range(0, 1);
            run_frame(fw, $urandom_range(0, 13), $urandom_range(0, 13),
                      $urandom_range(0, 7), $urandom_range(0, 7),
                      0, fw * fh, -1, 0, 1);
            drain("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
